// File: rtl/miriscv_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for miriscv_decode_stage.
interface miriscv_decode_stage_if #(
   parameter int unsigned ALU_OP_WIDTH = 5
);
   logic [31:0]             instr_i;
   logic [31:0]             pc_i;
   logic                    instr_valid_i;
   logic                    instr_ready_o;
   logic                    dec_valid_o;
   logic                    dec_ready_i;
   logic [31:0]             pc_o;
   logic [1:0]              ex_op_a_sel_o;
   logic [2:0]              ex_op_b_sel_o;
   logic [ALU_OP_WIDTH-1:0] alu_op_o;
   logic                    mdu_req_o;
   logic [2:0]              mdu_op_o;
   logic                    mem_req_o;
   logic                    mem_we_o;
   logic [2:0]              mem_size_o;
   logic                    gpr_we_a_o;
   logic [1:0]              wb_src_sel_o;
   logic [4:0]              rs1_o;
   logic [4:0]              rs2_o;
   logic [4:0]              rd_o;
   logic                    illegal_instr_o;
   logic                    branch_o;
   logic                    jal_o;
   logic                    jalr_o;

   modport master (
      output instr_i, pc_i, instr_valid_i, dec_ready_i,
      input  instr_ready_o, dec_valid_o, pc_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
             mdu_req_o, mdu_op_o, mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o,
             rs1_o, rs2_o, rd_o, illegal_instr_o, branch_o, jal_o, jalr_o
   );

   modport slave (
      input  instr_i, pc_i, instr_valid_i, dec_ready_i,
      output instr_ready_o, dec_valid_o, pc_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
             mdu_req_o, mdu_op_o, mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o,
             rs1_o, rs2_o, rd_o, illegal_instr_o, branch_o, jal_o, jalr_o
   );
endinterface

// File: rtl/miriscv_decode_stage.sv
// Registered RV32I(+M) decode stage with valid/ready handshakes, optional skid entry,
// flush and a saturating illegal-instruction counter.
`ifndef MIRISCV_DECODE_DEFINES
`define MIRISCV_DECODE_DEFINES
`define ALU_OP_WIDTH 5
`define ALU_ADD  5'b00000
`define ALU_SUB  5'b01000
`define ALU_XOR  5'b00100
`define ALU_OR   5'b00110
`define ALU_AND  5'b00111
`define ALU_SRA  5'b01101
`define ALU_SRL  5'b00101
`define ALU_SLL  5'b00001
`define ALU_LTS  5'b11100
`define ALU_LTU  5'b11110
`define ALU_GES  5'b11101
`define ALU_GEU  5'b11111
`define ALU_EQ   5'b11000
`define ALU_NE   5'b11001
`define ALU_SLTS 5'b00010
`define ALU_SLTU 5'b00011
`define LDST_B   3'b000
`define LDST_H   3'b001
`define LDST_W   3'b010
`define LDST_BU  3'b100
`define LDST_HU  3'b101
`endif

module miriscv_decode_stage #(
   parameter int unsigned ALU_OP_WIDTH = `ALU_OP_WIDTH,
   parameter bit          M_EXT        = 1'b0,
   parameter bit          SKID         = 1'b1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  flush_i,
   miriscv_decode_stage_if.slave bus,
   output logic [CNT_W-1:0]      illegal_cnt_o
);

   typedef struct packed {
      logic [31:0]             pc;
      logic [1:0]              a_sel;
      logic [2:0]              b_sel;
      logic [ALU_OP_WIDTH-1:0] alu_op;
      logic                    mdu_req;
      logic [2:0]              mdu_op;
      logic                    mem_req;
      logic                    mem_we;
      logic [2:0]              mem_size;
      logic                    gpr_we;
      logic [1:0]              wb_src;
      logic [4:0]              rs1;
      logic [4:0]              rs2;
      logic [4:0]              rd;
      logic                    illegal;
      logic                    branch;
      logic                    jal;
      logic                    jalr;
   } bundle_t;

   bundle_t          dec, out_d, out_q, skid_d, skid_q;
   logic             out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
   logic             ready_d, ready_q, in_fire, out_fire;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [31:0]      ins;
   logic [4:0]       opcode;
   logic [2:0]       f3;
   logic [6:0]       f7;

   assign ins    = bus.instr_i;
   assign opcode = ins[6:2];
   assign f3     = ins[14:12];
   assign f7     = ins[31:25];

   always_comb begin
      dec          = '0;
      dec.pc       = bus.pc_i;
      dec.rs1      = ins[19:15];
      dec.rs2      = ins[24:20];
      dec.rd       = ins[11:7];
      dec.alu_op   = `ALU_ADD;
      dec.mem_size = `LDST_W;
      if (ins[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end else begin
         case (opcode)
            5'b00000: begin // LOAD
               dec.b_sel = 3'd1; dec.mem_req = 1'b1; dec.gpr_we = 1'b1; dec.wb_src = 2'd1;
               dec.mem_size = f3;
               dec.illegal  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            5'b00011: ; // MISC_MEM: NOP
            5'b00100: begin // OP_IMM
               dec.b_sel = 3'd1; dec.gpr_we = 1'b1;
               case (f3)
                  3'b000: dec.alu_op = `ALU_ADD;
                  3'b010: dec.alu_op = `ALU_SLTS;
                  3'b011: dec.alu_op = `ALU_SLTU;
                  3'b100: dec.alu_op = `ALU_XOR;
                  3'b110: dec.alu_op = `ALU_OR;
                  3'b111: dec.alu_op = `ALU_AND;
                  3'b001: begin dec.alu_op = `ALU_SLL; dec.illegal = (f7 != 7'h00); end
                  default: begin
                     dec.alu_op  = (f7 == 7'h20) ? `ALU_SRA : `ALU_SRL;
                     dec.illegal = (f7 != 7'h00) && (f7 != 7'h20);
                  end
               endcase
            end
            5'b00101: begin dec.a_sel = 2'd1; dec.b_sel = 3'd2; dec.gpr_we = 1'b1; end
            5'b01000: begin // STORE
               dec.b_sel = 3'd3; dec.mem_req = 1'b1; dec.mem_we = 1'b1; dec.mem_size = f3;
               dec.illegal = (f3 > 3'b010);
            end
            5'b01100: begin // OP
               dec.gpr_we = 1'b1;
               if (f7 == 7'h00) begin
                  case (f3)
                     3'b000:  dec.alu_op = `ALU_ADD;
                     3'b001:  dec.alu_op = `ALU_SLL;
                     3'b010:  dec.alu_op = `ALU_SLTS;
                     3'b011:  dec.alu_op = `ALU_SLTU;
                     3'b100:  dec.alu_op = `ALU_XOR;
                     3'b101:  dec.alu_op = `ALU_SRL;
                     3'b110:  dec.alu_op = `ALU_OR;
                     default: dec.alu_op = `ALU_AND;
                  endcase
               end else if (f7 == 7'h20 && f3 == 3'b000) begin
                  dec.alu_op = `ALU_SUB;
               end else if (f7 == 7'h20 && f3 == 3'b101) begin
                  dec.alu_op = `ALU_SRA;
               end else if (f7 == 7'h01 && M_EXT) begin
                  dec.mdu_req = 1'b1; dec.mdu_op = f3; dec.wb_src = 2'd2;
               end else begin
                  dec.illegal = 1'b1;
               end
            end
            5'b01101: begin dec.a_sel = 2'd2; dec.b_sel = 3'd2; dec.gpr_we = 1'b1; end
            5'b11000: begin // BRANCH
               dec.branch = 1'b1;
               case (f3)
                  3'b000:  dec.alu_op = `ALU_EQ;
                  3'b001:  dec.alu_op = `ALU_NE;
                  3'b100:  dec.alu_op = `ALU_LTS;
                  3'b101:  dec.alu_op = `ALU_GES;
                  3'b110:  dec.alu_op = `ALU_LTU;
                  3'b111:  dec.alu_op = `ALU_GEU;
                  default: dec.illegal = 1'b1;
               endcase
            end
            5'b11001: begin
               dec.a_sel = 2'd1; dec.b_sel = 3'd4; dec.jalr = 1'b1; dec.gpr_we = 1'b1;
               dec.illegal = (f3 != 3'b000);
            end
            5'b11011: begin dec.a_sel = 2'd1; dec.b_sel = 3'd4; dec.jal = 1'b1; dec.gpr_we = 1'b1; end
            5'b11100: dec.illegal = (ins != 32'h0000_0073) && (ins != 32'h0010_0073);
            default:  dec.illegal = 1'b1;
         endcase
      end
      if (dec.illegal) begin
         dec.mem_req = 1'b0; dec.mem_we = 1'b0; dec.gpr_we = 1'b0; dec.mdu_req = 1'b0;
         dec.branch  = 1'b0; dec.jal    = 1'b0; dec.jalr   = 1'b0;
      end
      if (dec.rd == 5'd0) dec.gpr_we = 1'b0;
   end

   assign in_fire  = bus.instr_valid_i & bus.instr_ready_o & ~flush_i;
   assign out_fire = out_valid_q & bus.dec_ready_i;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || bus.dec_ready_i) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = in_fire;
            if (in_fire) skid_d = dec;
         end else begin
            out_valid_d = in_fire;
            if (in_fire) out_d = dec;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_d       = dec;
      end
      if (!SKID) skid_valid_d = 1'b0;
      ready_d = ~skid_valid_d;
      if (out_fire && !flush_i && out_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1; // masked by rst_n_i so ready rises right at release
         cnt_q        <= '0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.instr_ready_o   = rst_n_i & (SKID ? ready_q : (~out_valid_q | bus.dec_ready_i));
   assign bus.dec_valid_o     = out_valid_q;
   assign bus.pc_o            = out_q.pc;
   assign bus.ex_op_a_sel_o   = out_q.a_sel;
   assign bus.ex_op_b_sel_o   = out_q.b_sel;
   assign bus.alu_op_o        = out_q.alu_op;
   assign bus.mdu_req_o       = out_q.mdu_req;
   assign bus.mdu_op_o        = out_q.mdu_op;
   assign bus.mem_req_o       = out_q.mem_req;
   assign bus.mem_we_o        = out_q.mem_we;
   assign bus.mem_size_o      = out_q.mem_size;
   assign bus.gpr_we_a_o      = out_q.gpr_we;
   assign bus.wb_src_sel_o    = out_q.wb_src;
   assign bus.rs1_o           = out_q.rs1;
   assign bus.rs2_o           = out_q.rs2;
   assign bus.rd_o            = out_q.rd;
   assign bus.illegal_instr_o = out_q.illegal;
   assign bus.branch_o        = out_q.branch;
   assign bus.jal_o           = out_q.jal;
   assign bus.jalr_o          = out_q.jalr;
   assign illegal_cnt_o       = cnt_q;

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Directed bench: dut1 is SKID=1/M_EXT=1/CNT_W=16, dut0 is SKID=0/M_EXT=0/CNT_W=2.
module tb_miriscv_decode_stage;

   localparam logic [31:0] AluAdd = 32'd0;
   localparam logic [31:0] AluEq  = 32'd24;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [15:0] cnt1;
   logic [1:0]  cnt0;
   int          n_checks;
   int          n_fail;

   miriscv_decode_stage_if #(.ALU_OP_WIDTH(5)) if1 ();
   miriscv_decode_stage_if #(.ALU_OP_WIDTH(5)) if0 ();

   miriscv_decode_stage #(.ALU_OP_WIDTH(5), .M_EXT(1'b1), .SKID(1'b1), .CNT_W(16)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .bus(if1.slave), .illegal_cnt_o(cnt1)
   );

   miriscv_decode_stage #(.ALU_OP_WIDTH(5), .M_EXT(1'b0), .SKID(1'b0), .CNT_W(2)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .bus(if0.slave), .illegal_cnt_o(cnt0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      if1.instr_valid_i = v;
      if1.instr_i       = ins;
      if1.pc_i          = pc;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      drive1(1'b0, 32'h0, 32'h0);
      if1.dec_ready_i   = 1'b1;
      if0.instr_valid_i = 1'b0;
      if0.instr_i       = 32'h0;
      if0.pc_i          = 32'h0;
      if0.dec_ready_i   = 1'b1;

      // Reset
      repeat (3) step();
      check("rst_valid", if1.dec_valid_o, 0);
      check("rst_ready", if1.instr_ready_o, 0);
      check("rst_ready0", if0.instr_ready_o, 0);
      check("rst_pc", if1.pc_o, 0);
      check("rst_we", if1.gpr_we_a_o, 0);
      check("rst_cnt", cnt1, 0);
      rst_n = 1'b1;
      #1;
      check("rel_ready", if1.instr_ready_o, 1);
      check("rel_cnt", cnt1, 0);

      // Streaming addi / add
      drive1(1'b1, 32'h0050_0093, 32'h100);
      step();
      check("addi_valid", if1.dec_valid_o, 1);
      check("addi_alu", if1.alu_op_o, AluAdd);
      check("addi_bsel", if1.ex_op_b_sel_o, 1);
      check("addi_rd", if1.rd_o, 1);
      check("addi_we", if1.gpr_we_a_o, 1);
      check("addi_pc", if1.pc_o, 32'h100);
      drive1(1'b1, 32'h0020_8133, 32'h104);
      step();
      check("add_valid", if1.dec_valid_o, 1);
      check("add_bsel", if1.ex_op_b_sel_o, 0);
      check("add_rd", if1.rd_o, 2);
      check("add_rs1", if1.rs1_o, 1);
      check("add_rs2", if1.rs2_o, 2);
      check("add_we", if1.gpr_we_a_o, 1);
      drive1(1'b0, 32'h0, 32'h0);
      step();
      check("drain_valid", if1.dec_valid_o, 0);

      // Backpressure into the skid entry
      if1.dec_ready_i = 1'b0;
      drive1(1'b1, 32'h0010_0093, 32'h200);
      step();
      check("bp_ready1", if1.instr_ready_o, 1);
      drive1(1'b1, 32'h0020_0093, 32'h204);
      step();
      check("bp_ready_full", if1.instr_ready_o, 0);
      drive1(1'b1, 32'h0030_0093, 32'h208);
      step();
      check("bp_hold_pc", if1.pc_o, 32'h200);
      check("bp_hold_ready", if1.instr_ready_o, 0);
      if1.dec_ready_i = 1'b1;
      step();
      check("bp_out2_valid", if1.dec_valid_o, 1);
      check("bp_out2_pc", if1.pc_o, 32'h204);
      step();
      check("bp_out3_valid", if1.dec_valid_o, 1);
      check("bp_out3_pc", if1.pc_o, 32'h208);
      drive1(1'b0, 32'h0, 32'h0);
      step();
      check("bp_empty", if1.dec_valid_o, 0);

      // Illegal all-zero word
      drive1(1'b1, 32'h0000_0000, 32'h300);
      step();
      drive1(1'b0, 32'h0, 32'h0);
      check("ill_flag", if1.illegal_instr_o, 1);
      check("ill_mem", if1.mem_req_o, 0);
      check("ill_we", if1.gpr_we_a_o, 0);
      check("ill_cf", {if1.branch_o, if1.jal_o, if1.jalr_o, if1.mdu_req_o}, 0);
      check("ill_cnt_pre", cnt1, 0);
      step();
      check("ill_cnt", cnt1, 1);

      // MUL with M extension
      drive1(1'b1, 32'h0220_81B3, 32'h400);
      step();
      drive1(1'b0, 32'h0, 32'h0);
      check("mul_mdu", if1.mdu_req_o, 1);
      check("mul_op", if1.mdu_op_o, 0);
      check("mul_wb", if1.wb_src_sel_o, 2);
      check("mul_we", if1.gpr_we_a_o, 1);
      check("mul_ill", if1.illegal_instr_o, 0);
      step();

      // Assorted decode patterns, one per cycle
      drive1(1'b1, 32'h0081_2283, 32'h500); // lw x5,8(x2)
      step();
      check("lw_mem", {if1.mem_req_o, if1.mem_we_o}, 2'b10);
      check("lw_size", if1.mem_size_o, 2);
      check("lw_wb", if1.wb_src_sel_o, 1);
      check("lw_bsel", if1.ex_op_b_sel_o, 1);
      check("lw_rd", if1.rd_o, 5);
      drive1(1'b1, 32'h0051_2223, 32'h504); // sw x5,4(x2)
      step();
      check("sw_mem", {if1.mem_req_o, if1.mem_we_o}, 2'b11);
      check("sw_bsel", if1.ex_op_b_sel_o, 3);
      check("sw_we", if1.gpr_we_a_o, 0);
      drive1(1'b1, 32'h0020_8063, 32'h508); // beq x1,x2,0
      step();
      check("beq_br", if1.branch_o, 1);
      check("beq_alu", if1.alu_op_o, AluEq);
      check("beq_we", if1.gpr_we_a_o, 0);
      drive1(1'b1, 32'h0000_00EF, 32'h50C); // jal x1,0
      step();
      check("jal_flag", if1.jal_o, 1);
      check("jal_sel", {if1.ex_op_a_sel_o, if1.ex_op_b_sel_o}, {2'd1, 3'd4});
      check("jal_we", if1.gpr_we_a_o, 1);
      drive1(1'b1, 32'h0010_0073, 32'h510); // ebreak
      step();
      check("ebreak_ill", if1.illegal_instr_o, 0);
      drive1(1'b1, 32'h1050_0073, 32'h514); // other SYSTEM
      step();
      check("sys_ill", if1.illegal_instr_o, 1);
      drive1(1'b1, 32'h0000_0033, 32'h518); // add x0,x0,x0
      step();
      check("x0_ill", if1.illegal_instr_o, 0);
      check("x0_we", if1.gpr_we_a_o, 0);
      drive1(1'b0, 32'h0, 32'h0);
      step();
      check("cnt_two", cnt1, 2);

      // Flush with the skid entry full and a new input in the same cycle
      if1.dec_ready_i = 1'b0;
      drive1(1'b1, 32'h0010_0093, 32'h600);
      step();
      drive1(1'b1, 32'h0020_0093, 32'h604);
      step();
      drive1(1'b1, 32'h0030_0093, 32'h608);
      flush = 1'b1;
      step();
      check("fl_valid", if1.dec_valid_o, 0);
      check("fl_ready", if1.instr_ready_o, 1);
      drive1(1'b1, 32'h0040_0093, 32'h60C); // presented while flush held, ready=1
      step();
      check("fl_drop", if1.dec_valid_o, 0);
      flush = 1'b0;
      drive1(1'b0, 32'h0, 32'h0);
      if1.dec_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("fl_never", if1.dec_valid_o, 0);
      end
      check("fl_cnt", cnt1, 2);

      // dut0: MUL illegal without M, combinational ready, 2-bit saturation
      if0.dec_ready_i   = 1'b0;
      if0.instr_valid_i = 1'b1;
      if0.instr_i       = 32'h0220_81B3;
      if0.pc_i          = 32'h700;
      step();
      check("m0_ill", if0.illegal_instr_o, 1);
      check("m0_we", if0.gpr_we_a_o, 0);
      check("m0_mdu", if0.mdu_req_o, 0);
      check("m0_ready_stall", if0.instr_ready_o, 0);
      if0.dec_ready_i = 1'b1;
      #1;
      check("m0_ready_comb", if0.instr_ready_o, 1);
      if0.instr_i = 32'h0;
      step();
      step();
      check("m0_cnt2", cnt0, 2);
      step();
      step();
      if0.instr_valid_i = 1'b0;
      step();
      check("m0_sat", cnt0, 3);
      check("m0_empty", if0.dec_valid_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/miriscv_decode_stage.md
Name: miriscv_decode_stage

Overview:
- Registered, parametrised decode stage between fetch and execute; the successor to the purely combinational decoder.
- Decodes RV32I, plus RV32M when enabled, and holds the result in a pipeline register with valid/ready handshakes on both sides.
- Adds an optional 2-entry skid buffer, flush, side-effect suppression for illegal instructions, register-index outputs, and a saturating illegal-instruction counter.

Parameters:
ALU_OP_WIDTH, `ALU_OP_WIDTH, width of alu_op_o
M_EXT, 0, 1 = decode MUL/DIV group (OP opcode, funct7=0000001); 0 = illegal
SKID, 1, 1 = 2-entry skid buffer with registered instr_ready_o; 0 = single register with combinational ready
CNT_W, 16, width of illegal_cnt_o

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset; synchronous, active-low
flush_i  in  1  drop all held and incoming instructions
instr_i  in  32  fetched instruction
pc_i  in  32  PC of instr_i
instr_valid_i  in  1  instr_i/pc_i valid
instr_ready_o  out  1  stage can accept
dec_valid_o  out  1  decode bundle valid
dec_ready_i  in  1  execute consumes bundle
pc_o  out  32  PC of bundle
ex_op_a_sel_o  out  2  0=rs1, 1=PC, 2=zero
ex_op_b_sel_o  out  3  0=rs2, 1=imm_I, 2=imm_U, 3=imm_S, 4=const 4
alu_op_o  out  ALU_OP_WIDTH  `ALU_* code
mdu_req_o  out  1  MUL/DIV request
mdu_op_o  out  3  funct3 of the M instruction
mem_req_o  out  1  load/store
mem_we_o  out  1  store
mem_size_o  out  3  `LDST_* code
gpr_we_a_o  out  1  register-file write
wb_src_sel_o  out  2  0=ALU, 1=LSU, 2=MDU
rs1_o, rs2_o, rd_o  out  5 each  instr[19:15], [24:20], [11:7]
illegal_instr_o  out  1  illegal instruction
branch_o, jal_o, jalr_o  out  1 each  control-flow type
illegal_cnt_o  out  CNT_W  count of illegal instructions delivered

Behaviour:
- Reset (rst_n_i=0 at a clock edge): every output, the skid entry and the counter become 0. instr_ready_o is forced to 0 while rst_n_i=0 and is 1 in the first cycle after release.
- Decode (combinational on instr_i, then registered):
  - Legal RV32I opcodes: LOAD, STORE, OP, OP_IMM, LUI, AUIPC, BRANCH, JAL, JALR, MISC_MEM (executes as NOP).
  - Standard opcode/funct3/funct7 map onto the `ALU_*/`LDST_* codes.
  - Operand selects: LOAD 0/1; STORE 0/3; OP 0/0; OP_IMM 0/1; AUIPC 1/2; LUI 2/2; BRANCH 0/0; JAL and JALR 1/4.
  - SYSTEM is legal only for exactly 0x00000073 (ECALL) and 0x00100073 (EBREAK); all other SYSTEM encodings are illegal.
  - instr[1:0] != 2'b11, or any unlisted opcode/funct combination, is illegal.
- M group (OP opcode, funct7=0000001):
  - M_EXT=1: mdu_req_o=1, mdu_op_o=funct3, gpr_we_a_o=1, wb_src_sel_o=2.
  - M_EXT=0: illegal.
- Illegal instructions: force mem_req_o, mem_we_o, gpr_we_a_o, mdu_req_o, branch_o, jal_o, jalr_o to 0. ALU/select/size outputs are don't-care.
- rd=x0: gpr_we_a_o forced to 0.
- Handshake:
  - Input transfer occurs when instr_valid_i & instr_ready_o.
  - Output transfer occurs when dec_valid_o & dec_ready_i.
  - The bundle is stable while dec_valid_o=1 and dec_ready_i=0.
  - Latency is 1 cycle from input transfer to dec_valid_o; throughput is 1 instruction/cycle.
- SKID=1:
  - Output register plus one skid entry; instr_ready_o = !skid_full (a register output).
  - A transfer into a stalled, occupied output register goes to the skid entry.
  - On dec_ready_i with skid_full, the skid entry moves to the output and, in the same cycle, a new input may enter the skid entry.
- SKID=0: instr_ready_o = !dec_valid_o | dec_ready_i.
- Order is strictly FIFO; no instruction is duplicated or lost except by flush.
- Flush:
  - flush_i=1 at an edge clears dec_valid_o and the skid entry.
  - An input presented in the same cycle is dropped, even though instr_ready_o may read 1.
  - flush_i has priority over dec_ready_i. Counter is unaffected.
- illegal_cnt_o:
  - +1 on each output transfer with illegal_instr_o=1.
  - Saturates at 2^CNT_W-1. Cleared only by reset.
- Reset mid-stall: all held entries are discarded and dec_valid_o=0 after the edge.

Test Plan:
- Reset: hold rst_n_i=0 for 3 cycles -> all outputs 0, instr_ready_o=0; after release, instr_ready_o=1 and illegal_cnt_o=0.
- Stream, dec_ready_i=1: 0x00500093 (addi x1,x0,5) then 0x00208133 (add x2,x1,x2) -> one cycle after each accept, dec_valid_o=1.
  - addi: alu_op=`ALU_ADD, op_b_sel=1, rd_o=1.
  - add: op_b_sel=0, rd_o=2. Both with gpr_we_a_o=1.
- SKID=1 backpressure: dec_ready_i=0, send 3 back-to-back instructions -> 2 accepted, instr_ready_o=0. Raise dec_ready_i -> all 3 emerge in order with no gaps.
- Illegal handling:
  - 0x00000000 -> illegal_instr_o=1, all side-effect strobes 0, illegal_cnt_o=1.
  - With CNT_W=2, 5 illegal instructions -> illegal_cnt_o saturates at 3.
- M extension: 0x022081B3 (mul x3,x1,x2).
  - M_EXT=1 -> mdu_req_o=1, mdu_op_o=0, wb_src_sel_o=2.
  - M_EXT=0 -> illegal_instr_o=1, gpr_we_a_o=0.
- Flush with skid full, new input asserted in the same cycle -> next cycle dec_valid_o=0, instr_ready_o=1, and none of the 3 instructions ever appears at the output.
